pixel_apply: RTL and testbench
==============================

Name: pixel_apply

Overview:
- Downstream consumer of the pixel modifier stage (r_mod/g_mod/b_mod/div_flag).
- Applies per-channel multiply (saturating) or divide (power-of-two shift) to a streaming RGB pixel bus from the camera path before the VGA/frame-buffer writer.
- Modifiers are latched once per frame, at start-of-frame, so an audio-driven filter change never tears a frame.
- Stream uses a 2-stage registered pipeline with valid/ready backpressure.

Parameters:
- PIX_W, 8, bits per colour channel
- MOD_W, 6, width of each modifier input; fixed by the modifier stage

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- r_mod  in  MOD_W  red modifier
- g_mod  in  MOD_W  green modifier
- b_mod  in  MOD_W  blue modifier
- div_flag  in  1  1 = divide mode, 0 = multiply mode
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_sof  in  1  beat is first pixel of a frame
- in_eol  in  1  beat is last pixel of a line
- in_r / in_g / in_b  in  PIX_W each  input channels
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts a beat
- out_sof / out_eol  out  1 each  sideband, delayed with the pixel
- out_r / out_g / out_b  out  PIX_W each  processed channels

Behaviour:
- Reset is asynchronous, active-low, on rst_n. While asserted:
  - out_valid = 0, all internal valid bits = 0.
  - out_r/g/b/sof/eol = 0.
  - Shadow modifiers = {1,1,1}, shadow div = 0 (pass-through).
- Reset mid-frame drops all in-flight beats. No beat is emitted after rst_n deasserts until new input arrives.
- Handshake:
  - A beat transfers when valid and ready are both high on a rising edge.
  - out_valid, once high, holds with stable data until out_ready.
  - in_ready may depend combinationally on out_ready.
- Pipeline:
  - Stage 1 captures the pixel and sideband and computes raw results.
  - Stage 2 saturates/selects and registers the outputs.
  - Latency is 2 cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 beat/cycle.
- Ready logic:
  - s2_can_load = !out_valid || out_ready
  - s1_adv = s1_valid && s2_can_load
  - in_ready = !s1_valid || s1_adv
  - Consequence: a stalled pipeline holds exactly 2 beats, with no loss, duplication or reordering.
- Modifier latching:
  - Shadow registers load r/g/b_mod and div_flag on a transferring beat with in_sof = 1.
  - That same beat uses the newly sampled values.
  - Non-sof beats use the shadow values. Modifier input changes between sof beats are ignored.
- Arithmetic, per channel, unsigned:
  - Multiply (div = 0): p = pix × mod, width PIX_W + MOD_W. Out = p if p ≤ 2^PIX_W − 1, else 2^PIX_W − 1 (saturate). mod = 0 gives 0.
  - Divide (div = 1): out = pix >> k, where k = index of the highest set bit of mod (floor log2). mod = 0 gives out = 0. Non-power-of-two mod rounds down to the nearest power of two.
- Sideband: sof/eol travel with their pixel unchanged.
- Simultaneous in_sof transfer and stalled output: the latch occurs only on a transfer. It never occurs on a beat merely presented while in_ready = 0.

Decomposition:
- Shared package pixel_filt_pkg:
  - PIX_W and MOD_W localparams.
  - typedef rgb_t: packed struct {r, g, b}.
  - typedef mod_t: packed struct {r, g, b, div}.
  - Pass-through constant MOD_PASS = {1,1,1,0}, also usable by the modifier stage.
- Sub-module pixel_chan_apply: one channel's multiply/saturate and shift path, with a stage-1/stage-2 split. Instantiated 3×.
- Handshake and shadow-register logic live in the top module.

Test Plan:
- Pass-through: sof beat, mods {1,1,1}, div 0, pixel (0x12,0x34,0x56), out_ready = 1 -> out (0x12,0x34,0x56) with out_sof = 1, exactly 2 cycles after transfer.
- Saturating multiply: sof beat, mods {4,4,4}, div 0, pixel (0x30,0x40,0x41) -> (0xC0,0xFF,0xFF).
- Divide: sof beat, mods {4,2,1}, div 1, pixel (0xFF,0x03,0x80) -> (0x3F,0x01,0x80). Mod 0 with div 1 -> channel 0x00.
- Frame latch:
  - sof beat with mods {1,1,1}, then mods changed to {0,0,0} for 3 non-sof beats -> those outputs are unchanged pixels.
  - Next sof beat -> output (0,0,0).
- Backpressure: continuous input, out_ready low for 5 cycles -> in_ready low after 2 beats held; on release, all beats appear in order once each, with eol markers aligned.
- Reset mid-stream: assert rst_n = 0 while out_valid = 1 and 2 beats in flight -> out_valid drops immediately (asynchronous). After release, a non-sof beat with pixel 0x50 and inputs {2,2,2}, div 0 -> output 0x50 (shadow reverted to pass-through).

Source files
------------

// File: rtl/pixel_filt_pkg.sv
// Shared types and constants for the pixel filter path.
// Holds the channel/modifier widths, the RGB pixel and modifier structs,
// the pass-through modifier constant (also used by the modifier stage),
// and a floor-log2 helper for the divide path.
package pixel_filt_pkg;

    localparam int PIX_W   = 8;                 // bits per colour channel
    localparam int MOD_W   = 6;                 // bits per modifier
    localparam int PROD_W  = PIX_W + MOD_W;     // full multiply width
    localparam int SHIFT_W = $clog2(MOD_W);     // enough to index any modifier bit

    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [MOD_W-1:0] r;
        logic [MOD_W-1:0] g;
        logic [MOD_W-1:0] b;
        logic             div;
    } mod_t;

    // Unity multiply on every channel: the stream passes through untouched.
    localparam mod_t MOD_PASS = '{r: MOD_W'(1), g: MOD_W'(1), b: MOD_W'(1), div: 1'b0};

    // Index of the highest set bit (floor log2). Returns 0 for m == 0;
    // callers treat m == 0 separately.
    function automatic logic [SHIFT_W-1:0] msb_index(input logic [MOD_W-1:0] m);
        logic [SHIFT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MOD_W; i++) begin
            if (m[i]) idx = SHIFT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pixel_chan_apply.sv
// One colour channel of the pixel filter.
// Stage 1 registers the raw product and the shifted quotient; stage 2
// picks one according to the divide flag, saturates the product, and
// registers the result.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   s1_load     - capture pix/mod/div into stage 1
//   s2_load     - move stage 1 result into the output register
//   pix         - input channel value
//   mod, div    - effective modifier and mode for this beat
//   res         - processed channel value (registered)
module pixel_chan_apply
    import pixel_filt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1_load,
    input  logic             s2_load,
    input  logic [PIX_W-1:0] pix,
    input  logic [MOD_W-1:0] mod,
    input  logic             div,
    output logic [PIX_W-1:0] res
);

    logic [PROD_W-1:0] prod_c, prod_q;
    logic [PIX_W-1:0]  quot_c, quot_q;
    logic              div_q;
    logic [PIX_W-1:0]  res_c;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here: unconditional assignments), so no latch can be inferred.
    always_comb begin
        prod_c = PROD_W'(pix) * PROD_W'(mod);
        // A zero modifier in divide mode blanks the channel.
        quot_c = (mod == '0) ? '0 : (pix >> msb_index(mod));
    end

    always_comb begin
        res_c = prod_q[PIX_W-1:0];
        if (div_q) begin
            res_c = quot_q;
        end else if (prod_q > PROD_W'(PIX_MAX)) begin
            res_c = PIX_MAX;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: datapath registers are reset as well; that is what makes the
    // outputs read 0 during reset, and it keeps the stage-1 contents
    // deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            quot_q <= '0;
            div_q  <= 1'b0;
            res    <= '0;
        end else begin
            if (s1_load) begin
                prod_q <= prod_c;
                quot_q <= quot_c;
                div_q  <= div;
            end
            if (s2_load) begin
                res <= res_c;
            end
        end
    end

endmodule

// File: rtl/pixel_apply.sv
// Per-channel multiply/divide applied to a streaming RGB pixel bus.
// Modifiers are sampled into shadow registers on the transferring
// start-of-frame beat, so a whole frame always uses one modifier set.
// Two-stage registered pipeline with valid/ready backpressure.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   r_mod, g_mod, b_mod        - per-channel modifiers
//   div_flag                   - 1 = divide (shift), 0 = saturating multiply
//   in_valid/in_ready          - input handshake
//   in_sof, in_eol             - start-of-frame / end-of-line sideband
//   in_r, in_g, in_b           - input pixel
//   out_valid/out_ready        - output handshake
//   out_sof, out_eol           - sideband, delayed with the pixel
//   out_r, out_g, out_b        - processed pixel
module pixel_apply
    import pixel_filt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MOD_W-1:0] r_mod,
    input  logic [MOD_W-1:0] g_mod,
    input  logic [MOD_W-1:0] b_mod,
    input  logic             div_flag,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eol,
    output logic [PIX_W-1:0] out_r,
    output logic [PIX_W-1:0] out_g,
    output logic [PIX_W-1:0] out_b
);

    logic s1_valid, s1_sof, s1_eol;
    logic s2_can_load, s1_adv, in_xfer;
    mod_t shadow_q, mod_in, mod_eff;
    rgb_t pix_in, pix_out;

    assign s2_can_load = !out_valid || out_ready;
    assign s1_adv      = s1_valid && s2_can_load;
    assign in_ready    = !s1_valid || s1_adv;
    assign in_xfer     = in_valid && in_ready;

    assign mod_in = '{r: r_mod, g: g_mod, b: b_mod, div: div_flag};
    // The sof beat itself already uses the freshly presented modifiers.
    assign mod_eff = in_sof ? mod_in : shadow_q;

    assign pix_in = '{r: in_r, g: in_g, b: in_b};
    assign out_r  = pix_out.r;
    assign out_g  = pix_out.g;
    assign out_b  = pix_out.b;

    // Shadow only updates on an actual transfer, never on a beat that is
    // presented while in_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= MOD_PASS;
        end else if (in_xfer && in_sof) begin
            shadow_q <= mod_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_sof   <= in_sof;
                s1_eol   <= in_eol;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                out_valid <= 1'b1;
                out_sof   <= s1_sof;
                out_eol   <= s1_eol;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    pixel_chan_apply u_chan_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_load (in_xfer),
        .s2_load (s1_adv),
        .pix     (pix_in.r),
        .mod     (mod_eff.r),
        .div     (mod_eff.div),
        .res     (pix_out.r)
    );

    pixel_chan_apply u_chan_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_load (in_xfer),
        .s2_load (s1_adv),
        .pix     (pix_in.g),
        .mod     (mod_eff.g),
        .div     (mod_eff.div),
        .res     (pix_out.g)
    );

    pixel_chan_apply u_chan_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_load (in_xfer),
        .s2_load (s1_adv),
        .pix     (pix_in.b),
        .mod     (mod_eff.b),
        .div     (mod_eff.div),
        .res     (pix_out.b)
    );

endmodule

// File: tb/tb_pixel_apply.sv
// Directed bench for pixel_apply: a table of single-beat vectors with
// hand-computed results, plus streaming sequences for frame latching,
// backpressure, stalled-sof presentation and reset mid-stream.
module tb_pixel_apply;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] r_mod, g_mod, b_mod;
    logic       div_flag;
    logic       in_valid, in_ready, in_sof, in_eol;
    logic [7:0] in_r, in_g, in_b;
    logic       out_valid, out_ready, out_sof, out_eol;
    logic [7:0] out_r, out_g, out_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       sof;
        logic       eol;
        logic [5:0] mr, mg, mb;
        logic       div;
        logic [7:0] r, g, b;
        logic [7:0] er, eg, eb;
    } beat_t;

    beat_t vec[7];
    beat_t stream[8];

    always #5 clk = ~clk;

    pixel_apply dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_mod     (r_mod),
        .g_mod     (g_mod),
        .b_mod     (b_mod),
        .div_flag  (div_flag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic beat_t mk(input logic sof, input logic eol,
                                 input logic [5:0] mr, input logic [5:0] mg, input logic [5:0] mb,
                                 input logic div,
                                 input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        beat_t t;
        t.sof = sof; t.eol = eol;
        t.mr = mr; t.mg = mg; t.mb = mb; t.div = div;
        t.r = r; t.g = g; t.b = b;
        t.er = er; t.eg = eg; t.eb = eb;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input beat_t b);
        in_sof = b.sof; in_eol = b.eol;
        r_mod = b.mr; g_mod = b.mg; b_mod = b.mb; div_flag = b.div;
        in_r = b.r; in_g = b.g; in_b = b.b;
    endtask

    task automatic check_out(input string name, input beat_t b);
        check({name, " r"}, 32'(out_r), 32'(b.er));
        check({name, " g"}, 32'(out_g), 32'(b.eg));
        check({name, " b"}, 32'(out_b), 32'(b.eb));
        check({name, " sof"}, 32'(out_sof), 32'(b.sof));
        check({name, " eol"}, 32'(out_eol), 32'(b.eol));
    endtask

    // One beat into an empty pipeline; output must appear exactly two
    // cycles after the beat is presented (not earlier).
    task automatic send_one(input string name, input beat_t b);
        tick();
        out_ready = 1'b1;
        drive(b);
        in_valid = 1'b1;
        #1;
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check({name, " not early"}, 32'(out_valid), 32'd0);
        tick();
        #1;
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check_out(name, b);
    endtask

    // Streams stream[0..n-1] back-to-back; out_ready is held low for
    // stall_len cycles starting at cycle stall_start. Outputs must match
    // in order, once each.
    task automatic run_stream(input string name, input int n, input int stall_start, input int stall_len);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        while (got < n && cyc < 200) begin
            tick();
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            if (sent < n) begin
                drive(stream[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_len > 0 && cyc == stall_start + stall_len - 1) begin
                check({name, " stalled in_ready"}, 32'(in_ready), 32'd0);
                check({name, " stalled out_valid"}, 32'(out_valid), 32'd1);
                check({name, " beats held"}, 32'(sent), 32'd2);
            end
            if (out_valid && out_ready) begin
                check_out($sformatf("%s beat%0d", name, got), stream[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check({name, " all beats out"}, 32'(got), 32'(n));
        tick();
        tick();
        #1;
        check({name, " no extra beat"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // sof eol  mods r/g/b   div  pixel r/g/b         expected r/g/b
        vec[0] = mk(1, 0,  1,  1,  1, 0, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56);
        vec[1] = mk(1, 0,  4,  4,  4, 0, 8'h30, 8'h40, 8'h41, 8'hC0, 8'hFF, 8'hFF);
        vec[2] = mk(1, 1,  4,  2,  1, 1, 8'hFF, 8'h03, 8'h80, 8'h3F, 8'h01, 8'h80);
        vec[3] = mk(1, 0,  0,  8,  3, 1, 8'hAA, 8'hF0, 8'h0F, 8'h00, 8'h1E, 8'h07);
        vec[4] = mk(1, 1,  0, 63,  3, 0, 8'hAA, 8'h04, 8'h55, 8'h00, 8'hFC, 8'hFF);
        vec[5] = mk(1, 0, 63, 32, 16, 1, 8'hFF, 8'hE0, 8'h10, 8'h07, 8'h07, 8'h01);
        // Non-sof beat: presented mods ignored, shadow {63,32,16,div} applies.
        vec[6] = mk(0, 1,  1,  1,  1, 0, 8'h80, 8'h40, 8'h20, 8'h04, 8'h02, 8'h02);

        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_r", 32'(out_r), 32'd0);
        check("reset out_sof", 32'(out_sof), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send_one($sformatf("vec%0d", i), vec[i]);
        end

        // Frame latch: modifier changes between sof beats are ignored.
        stream[0] = mk(1, 0, 1, 1, 1, 0, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33);
        stream[1] = mk(0, 0, 0, 0, 0, 0, 8'h44, 8'h55, 8'h66, 8'h44, 8'h55, 8'h66);
        stream[2] = mk(0, 0, 0, 0, 0, 0, 8'h77, 8'h88, 8'h99, 8'h77, 8'h88, 8'h99);
        stream[3] = mk(0, 1, 0, 0, 0, 0, 8'hAA, 8'hBB, 8'hCC, 8'hAA, 8'hBB, 8'hCC);
        stream[4] = mk(1, 0, 0, 0, 0, 0, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00, 8'h00);
        stream[5] = mk(0, 1, 5, 5, 5, 0, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00);
        run_stream("latch", 6, 0, 0);

        // Backpressure: 8 beats, out_ready low for cycles 2..6.
        for (int i = 0; i < 8; i++) begin
            stream[i] = mk(i == 0, (i % 4) == 3, 1, 1, 1, 0,
                           8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i),
                           8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i));
        end
        run_stream("bp", 8, 2, 5);

        // A sof beat presented while stalled must not update the shadow.
        send_one("guard pre", mk(1, 0, 2, 2, 2, 0, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20));
        tick();
        out_ready = 1'b0;
        drive(mk(0, 0, 7, 7, 7, 1, 8'h01, 8'h01, 8'h01, 0, 0, 0));
        in_valid = 1'b1;
        tick();
        drive(mk(0, 0, 7, 7, 7, 1, 8'h02, 8'h02, 8'h02, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(mk(1, 0, 0, 0, 0, 1, 8'h77, 8'h77, 8'h77, 0, 0, 0));
            #1;
            check("guard stalled in_ready", 32'(in_ready), 32'd0);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("guard drain0 valid", 32'(out_valid), 32'd1);
        check("guard drain0 r", 32'(out_r), 32'h02);
        tick();
        #1;
        check("guard drain1 valid", 32'(out_valid), 32'd1);
        check("guard drain1 b", 32'(out_b), 32'h04);
        tick();
        #1;
        check("guard drained", 32'(out_valid), 32'd0);
        send_one("guard post", mk(0, 0, 0, 0, 0, 1, 8'h30, 8'h31, 8'h32, 8'h60, 8'h62, 8'h64));

        // Reset mid-stream with two beats in flight.
        tick();
        out_ready = 1'b0;
        drive(mk(1, 0, 3, 3, 3, 0, 8'h10, 8'h10, 8'h10, 0, 0, 0));
        in_valid = 1'b1;
        tick();
        drive(mk(0, 1, 3, 3, 3, 0, 8'h11, 8'h11, 8'h11, 0, 0, 0));
        tick();
        tick();
        #1;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        check("pre-reset in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset out_r", 32'(out_r), 32'd0);
        check("async reset out_eol", 32'(out_eol), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("post-reset idle", 32'(out_valid), 32'd0);
        end
        send_one("post-reset pass", mk(0, 0, 2, 2, 2, 0, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50));

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
